// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU,
// the unified memory port, the register file and the immediate generator.
module multicycle_ctrl #(
  parameter int OP_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            zero,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_write,
  output logic            adr_src,
  output logic            ir_write,
  output logic            pc_write,
  output logic            reg_write,
  output logic [1:0]      result_src,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [3:0]      alu_control,
  output logic [2:0]      imm_src,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR, S_LINK,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state_reg, state_next;
  logic   from_jalr_reg;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_FETCH;
      from_jalr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // LINK is shared by jal (entered from DECODE) and jalr; remember which.
      if (state_reg == S_JALR)
        from_jalr_reg <= 1'b1;
      else if (state_reg == S_DECODE)
        from_jalr_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_control = ALU_ADD;
    imm_src     = 3'd0;
    illegal     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'd2;
          result_src = 2'd2;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jal target into ALUOut.
        alu_src_a = 2'd1;
        if (op == OP_BRANCH)
          imm_src = 3'd2;
        else if (op == OP_JAL)
          imm_src = 3'd3;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_LINK;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        if (op == OP_STORE) begin
          imm_src    = 3'd1;
          state_next = S_MEMWRITE;
        end else begin
          state_next = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ack)
          state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ack)
          state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd1;
        alu_control = alu_dec(funct3, funct7b5);
        state_next  = S_ALU_WB;
      end
      S_EXEC_I: begin
        // addi has no subtract form: bit 30 belongs to the immediate there.
        alu_src_a   = 2'd2;
        alu_control = alu_dec(funct3, (funct3 == 3'b000) ? 1'b0 : funct7b5);
        state_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        state_next = S_FETCH;
        case (funct3)
          3'b000: begin alu_control = ALU_SUB;  pc_write = zero;  end
          3'b001: begin alu_control = ALU_SUB;  pc_write = !zero; end
          3'b100: begin alu_control = ALU_SLT;  pc_write = !zero; end
          3'b101: begin alu_control = ALU_SLT;  pc_write = zero;  end
          3'b110: begin alu_control = ALU_SLTU; pc_write = !zero; end
          3'b111: begin alu_control = ALU_SLTU; pc_write = zero;  end
          default: state_next = S_TRAP;
        endcase
      end
      S_JALR: begin
        alu_src_a  = 2'd2;
        result_src = 2'd2;
        pc_write   = 1'b1;
        state_next = S_LINK;
      end
      S_LINK: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        if (!from_jalr_reg)
          pc_write = 1'b1;
        state_next = S_ALU_WB;
      end
      S_LUI: begin
        imm_src     = 3'd4;
        alu_control = ALU_PASS;
        state_next  = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a  = 2'd1;
        imm_src    = 3'd4;
        state_next = S_ALU_WB;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_next = S_TRAP;
    endcase

    // Reset overrides everything so no strobe leaks out during an async reset.
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'd0;
      alu_src_a   = 2'd0;
      alu_src_b   = 2'd0;
      alu_control = ALU_ADD;
      imm_src     = 3'd0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class state by
// state and compares the packed control outputs against hand-built vectors.
module tb_multicycle_ctrl;
  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;

  int total_cnt;
  int bad_cnt;
  int ir_cnt;
  int ir_base;

  logic [19:0] outs;
  assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ir_write) ir_cnt++;

  // Field order: mem_req mem_write adr_src ir_write pc_write reg_write
  //              result_src alu_src_a alu_src_b alu_control imm_src illegal
  function automatic logic [19:0] ov(input logic mr, input logic mw, input logic as,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [3:0] ac,
                                     input logic [2:0] is, input logic ill);
    ov = {mr, mw, as, irw, pcw, rw, rs, sa, sb, ac, is, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic st(input string tag, input logic [19:0] e);
    @(negedge clk);
    chk(tag, {12'd0, outs}, {12'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic set_insn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  logic [19:0] fetch_ack;
  logic [19:0] dec_i;

  initial begin
    total_cnt = 0; bad_cnt = 0; ir_cnt = 0;
    fetch_ack = ov(1,0,0,1,1,0,2'd2,2'd0,2'd2,4'd0,3'd0,0);
    dec_i     = ov(0,0,0,0,0,0,2'd0,2'd1,2'd0,4'd0,3'd0,0);
    rst_n = 1'b0; mem_ack = 1'b1; zero = 1'b0;
    set_insn(7'b0110011, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {12'd0, outs}, 32'd0);
    rst_n = 1'b1;

    // add x3,x1,x2 with ack tied high
    st("add_fetch",  fetch_ack);
    st("add_decode", dec_i);
    st("add_exec",   ov(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,3'd0,0));
    st("add_wb",     ov(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    $display("insn add done");

    // sra (R, funct3 101, bit30 set)
    set_insn(7'b0110011, 3'b101, 1'b1);
    st("sra_fetch",  fetch_ack);
    st("sra_decode", dec_i);
    st("sra_exec",   ov(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd9,3'd0,0));
    st("sra_wb",     ov(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    $display("insn sra done");

    // addi with bit30 set must stay ADD
    set_insn(7'b0010011, 3'b000, 1'b1);
    st("addi_fetch",  fetch_ack);
    st("addi_decode", dec_i);
    st("addi_exec",   ov(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd0,3'd0,0));
    st("addi_wb",     ov(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    $display("insn addi done");

    // lw with three wait states in both FETCH and MEMREAD (11 cycles)
    set_insn(7'b0000011, 3'b010, 1'b0);
    ir_base = ir_cnt;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) st("lw_fetch_wait", ov(1,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    mem_ack = 1'b1;
    st("lw_fetch_ack", fetch_ack);
    mem_ack = 1'b0;
    st("lw_decode", dec_i);
    st("lw_memadr", ov(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd0,3'd0,0));
    for (int i = 0; i < 3; i++) st("lw_memrd_wait", ov(1,0,1,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    mem_ack = 1'b1;
    st("lw_memrd_ack", ov(1,0,1,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    st("lw_memwb",     ov(0,0,0,0,0,1,2'd1,2'd0,2'd0,4'd0,3'd0,0));
    chk("lw_ir_pulses", ir_cnt - ir_base, 32'd1);
    $display("insn lw done");

    // beq taken
    set_insn(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    st("beq_fetch",  fetch_ack);
    st("beq_decode", ov(0,0,0,0,0,0,2'd0,2'd1,2'd0,4'd0,3'd2,0));
    st("beq_branch", ov(0,0,0,0,1,0,2'd0,2'd2,2'd1,4'd1,3'd0,0));
    $display("insn beq done");

    // bge not taken (zero = 0 means rs1 < rs2)
    set_insn(7'b1100011, 3'b101, 1'b0);
    zero = 1'b0;
    st("bge_fetch",  fetch_ack);
    st("bge_decode", ov(0,0,0,0,0,0,2'd0,2'd1,2'd0,4'd0,3'd2,0));
    st("bge_branch", ov(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd5,3'd0,0));
    $display("insn bge done");

    // bltu taken
    set_insn(7'b1100011, 3'b110, 1'b0);
    st("bltu_fetch",  fetch_ack);
    st("bltu_decode", ov(0,0,0,0,0,0,2'd0,2'd1,2'd0,4'd0,3'd2,0));
    st("bltu_branch", ov(0,0,0,0,1,0,2'd0,2'd2,2'd1,4'd6,3'd0,0));
    $display("insn bltu done");

    // jal
    set_insn(7'b1101111, 3'b000, 1'b0);
    st("jal_fetch",  fetch_ack);
    st("jal_decode", ov(0,0,0,0,0,0,2'd0,2'd1,2'd0,4'd0,3'd3,0));
    st("jal_link",   ov(0,0,0,0,1,0,2'd0,2'd1,2'd2,4'd0,3'd0,0));
    st("jal_wb",     ov(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    $display("insn jal done");

    // jalr
    set_insn(7'b1100111, 3'b000, 1'b0);
    st("jalr_fetch",  fetch_ack);
    st("jalr_decode", dec_i);
    st("jalr_jalr",   ov(0,0,0,0,1,0,2'd2,2'd2,2'd0,4'd0,3'd0,0));
    st("jalr_link",   ov(0,0,0,0,0,0,2'd0,2'd1,2'd2,4'd0,3'd0,0));
    st("jalr_wb",     ov(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    $display("insn jalr done");

    // lui and auipc
    set_insn(7'b0110111, 3'b000, 1'b0);
    st("lui_fetch",  fetch_ack);
    st("lui_decode", dec_i);
    st("lui_exec",   ov(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd10,3'd4,0));
    st("lui_wb",     ov(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    set_insn(7'b0010111, 3'b000, 1'b0);
    st("auipc_fetch",  fetch_ack);
    st("auipc_decode", dec_i);
    st("auipc_exec",   ov(0,0,0,0,0,0,2'd0,2'd1,2'd0,4'd0,3'd4,0));
    st("auipc_wb",     ov(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    $display("insn lui/auipc done");

    // sw, reset pulsed during MEMWRITE wait
    set_insn(7'b0100011, 3'b010, 1'b0);
    st("sw_fetch",  fetch_ack);
    mem_ack = 1'b0;
    st("sw_decode", dec_i);
    st("sw_memadr", ov(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd0,3'd1,0));
    st("sw_memwr_wait", ov(1,1,1,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("sw_reset_outs", {12'd0, outs}, 32'd0);
    @(posedge clk);
    #1;
    chk("sw_reset_hold", {12'd0, outs}, 32'd0);
    rst_n = 1'b1;
    st("sw_after_reset", ov(1,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0));
    $display("insn sw/reset done");

    // illegal opcode 0x7F traps and stays trapped
    mem_ack = 1'b1;
    set_insn(7'h7F, 3'b000, 1'b0);
    st("ill_fetch",  fetch_ack);
    st("ill_decode", dec_i);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ill_trap_req", {31'd0, mem_req}, 32'd0);
      chk("ill_trap_flag", {31'd0, illegal}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk("ill_trap_outs", {12'd0, outs}, {12'd0, ov(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,1)});
    $display("insn illegal-op done");

    // bad branch funct3 traps from BRANCH
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    set_insn(7'b1100011, 3'b010, 1'b0);
    zero = 1'b1;
    st("bbad_fetch",  fetch_ack);
    st("bbad_decode", ov(0,0,0,0,0,0,2'd0,2'd1,2'd0,4'd0,3'd2,0));
    st("bbad_branch", ov(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,3'd0,0));
    for (int i = 0; i < 3; i++)
      st("bbad_trap", ov(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,1));
    $display("insn bad-branch done");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
